// File: rtl/wb_arb_pkg.sv
// Shared constants, write-port record types and a population-count helper
// for the register-file writeback arbiter.
package wb_arb_pkg;

    localparam int XLEN    = 64;
    localparam int AW      = 5;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
    } wb_req_t;

    typedef struct packed {
        logic            wen;
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
    } rf_wr_t;

    function automatic logic [3:0] popcount(input logic [MAX_REQ-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N,
// the first requester found wins. Reusable by any port sharer.
module rr_arbiter #(
    parameter int  N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        // Walk from the farthest offset down so the offset closest to ptr overrides.
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (req[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    gnt_idx  = PW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback sources with a
// round-robin grant and one registered output stage. Optional macro: WB_ARB_X0_DROP_EN.
module wb_port_arbiter #(
    parameter int  NUM_REQ = 3,
    parameter int  XLEN    = wb_arb_pkg::XLEN,
    parameter int  AW      = wb_arb_pkg::AW,
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*AW-1:0]   req_waddr,
    input  logic [NUM_REQ*XLEN-1:0] req_wdata,
    input  logic                    wb_hold,
    output logic                    rf_wen,
    output logic [AW-1:0]           rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [GW-1:0]           grant_id,
    output logic [7:0]              busy_cnt
);
    import wb_arb_pkg::*;

    typedef struct packed {
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
    } src_t;

    src_t               src [NUM_REQ];
    src_t               sel;
    logic [NUM_REQ-1:0] gnt;
    logic [GW-1:0]      gnt_idx;
    logic               arb_en;
    logic               fire;
    logic               emit_wen;

    logic               wen_q,   wen_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [GW-1:0]      gid_q,   gid_d;
    logic [GW-1:0]      ptr_q,   ptr_d;
    logic [7:0]         busy_q,  busy_d;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign src[gi] = {req_waddr[gi*AW +: AW], req_wdata[gi*XLEN +: XLEN]};
        end
    endgenerate

    assign arb_en = !wb_hold && !rst;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign fire      = |gnt;
    assign sel       = src[gnt_idx];

`ifdef WB_ARB_X0_DROP_EN
    // x0 writes still complete the handshake but never reach the regfile or bypass.
    assign emit_wen = fire && (sel.waddr != '0);
`else
    assign emit_wen = fire;
`endif

    always_comb begin
        wen_d   = emit_wen;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        if (fire) begin
            waddr_d = sel.waddr;
            wdata_d = sel.wdata;
            gid_d   = gnt_idx;
            ptr_d   = (gnt_idx == GW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        if ((popcount(MAX_REQ'(req_valid)) >= 4'd2) && !wb_hold && (busy_q != 8'hFF)) begin
            busy_d = busy_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign rf_wen   = wen_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign grant_id = gid_q;
    assign busy_cnt = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter with three sources.
module tb_wb_port_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   req_valid = '0;
    logic [2:0]   req_ready;
    logic [14:0]  req_waddr = '0;
    logic [191:0] req_wdata = '0;
    logic         wb_hold = 1'b0;
    logic         rf_wen;
    logic [4:0]   rf_waddr;
    logic [63:0]  rf_wdata;
    logic [1:0]   grant_id;
    logic [7:0]   busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic        v [3];
    logic [4:0]  a [3];
    logic [63:0] d [3];

    always #5 clk = ~clk;

    wb_port_arbiter #(.NUM_REQ(3), .XLEN(64), .AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_waddr (req_waddr),
        .req_wdata (req_wdata),
        .wb_hold   (wb_hold),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .busy_cnt  (busy_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            req_valid[i]           = v[i];
            req_waddr[i*5 +: 5]    = a[i];
            req_wdata[i*64 +: 64]  = d[i];
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0;
            a[i] = '0;
            d[i] = '0;
        end
        drive();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wb_hold = 1'b0;
        clear_src();
        step();
        step();
        check_val("rst_wen", rf_wen, 0);
        check_val("rst_waddr", rf_waddr, 0);
        check_val("rst_wdata", rf_wdata, 0);
        check_val("rst_gid", grant_id, 0);
        check_val("rst_busy", busy_cnt, 0);
        rst = 1'b0;
    endtask

    // random-phase model state
    int          mptr, mbusy, win, seq, max_wait, acc_cnt, emit_cnt, exp_emit;
    int          rand_err, stab_err, pwin, nvalid;
    int          wait_c [3];
    logic        pv [3];
    logic [4:0]  pa [3];
    logic [63:0] pd [3];
    logic [2:0]  exp_rdy;
    logic        exp_wen;
    logic [4:0]  last_a;
    logic [63:0] last_d;
    logic [1:0]  last_g;

    initial begin
        clear_src();
        #1;

        // 1: single source
        do_reset();
        v[1] = 1'b1; a[1] = 5'd5; d[1] = 64'hDEAD; drive();
        #2 check_val("t1_ready", req_ready, 3'b010);
        step();
        clear_src();
        check_val("t1_wen", rf_wen, 1);
        check_val("t1_waddr", rf_waddr, 5);
        check_val("t1_wdata", rf_wdata, 64'hDEAD);
        check_val("t1_gid", grant_id, 1);

        // 2: all sources valid, rotating grants
        do_reset();
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b1; a[i] = 5'(i + 1); d[i] = 64'(16 * i);
        end
        drive();
        for (int k = 0; k < 6; k++) begin
            logic [63:0] ed;
            int g;
            g = k % 3;
            ed = d[g];
            #2 check_val($sformatf("t2_ready%0d", k), req_ready, 3'b001 << g);
            step();
            check_val($sformatf("t2_wen%0d", k), rf_wen, 1);
            check_val($sformatf("t2_gid%0d", k), grant_id, 64'(g));
            check_val($sformatf("t2_wdata%0d", k), rf_wdata, ed);
            d[g] = d[g] + 64'd100;
            drive();
        end
        check_val("t2_busy", busy_cnt, 6);
        clear_src();

        // 3: hold freezes acceptance
        do_reset();
        v[0] = 1'b1; a[0] = 5'd3; d[0] = 64'h30;
        v[2] = 1'b1; a[2] = 5'd4; d[2] = 64'h40;
        wb_hold = 1'b1; drive();
        for (int k = 0; k < 3; k++) begin
            #2 check_val($sformatf("t3_ready%0d", k), req_ready, 0);
            step();
            check_val($sformatf("t3_wen%0d", k), rf_wen, 0);
        end
        wb_hold = 1'b0;
        #2 check_val("t3_rel_ready", req_ready, 3'b001);
        step();
        check_val("t3_rel_gid", grant_id, 0);
        check_val("t3_rel_wdata", rf_wdata, 64'h30);
        check_val("t3_busy", busy_cnt, 1);
        clear_src();

        // 4: reset right after an accept
        do_reset();
        v[2] = 1'b1; a[2] = 5'd9; d[2] = 64'h22; drive();
        #2 check_val("t4_ready", req_ready, 3'b100);
        step();
        rst = 1'b1;
        clear_src();
        v[0] = 1'b1; a[0] = 5'd1; d[0] = 64'h11; drive();
        #2 check_val("t4_rst_ready", req_ready, 0);
        check_val("t4_rst_wen", rf_wen, 1);
        check_val("t4_rst_gid", grant_id, 2);
        check_val("t4_rst_waddr", rf_waddr, 9);
        step();
        check_val("t4_after_wen", rf_wen, 0);
        rst = 1'b0;
        v[1] = 1'b1; a[1] = 5'd2; d[1] = 64'h12; drive();
        #2 check_val("t4_next_ready", req_ready, 3'b001);
        step();
        check_val("t4_next_gid", grant_id, 0);
        clear_src();

        // 5: write to x0
        do_reset();
        v[0] = 1'b1; a[0] = 5'd0; d[0] = 64'd7; drive();
        #2 check_val("t5_ready", req_ready, 3'b001);
        step();
`ifdef WB_ARB_X0_DROP_EN
        check_val("t5_wen", rf_wen, 0);
`else
        check_val("t5_wen", rf_wen, 1);
        check_val("t5_waddr", rf_waddr, 0);
        check_val("t5_wdata", rf_wdata, 7);
`endif
        a[0] = 5'd3; d[0] = 64'd8;
        v[1] = 1'b1; a[1] = 5'd4; d[1] = 64'd9; drive();
        #2 check_val("t5_ptr_ready", req_ready, 3'b010);
        step();
        clear_src();

        // 6: random stimulus against a reference model
        do_reset();
        mptr = 0; mbusy = 0; seq = 0; max_wait = 0; acc_cnt = 0; emit_cnt = 0;
        exp_emit = 0; rand_err = 0; stab_err = 0; pwin = -1;
        last_a = '0; last_d = '0; last_g = '0;
        for (int i = 0; i < 3; i++) begin
            wait_c[i] = 0; pv[i] = 1'b0; pa[i] = '0; pd[i] = '0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v[i] && ($urandom_range(0, 1) == 1)) begin
                    v[i] = 1'b1;
                    a[i] = 5'($urandom_range(0, 31));
                    d[i] = (64'(i) << 32) | 64'(seq);
                    seq++;
                end
            end
            wb_hold = ($urandom_range(0, 4) == 0);
            drive();
            for (int i = 0; i < 3; i++) begin
                if (pv[i] && (pwin != i) && (!v[i] || a[i] != pa[i] || d[i] != pd[i])) begin
                    stab_err++;
                end
            end
            #2;
            win = -1;
            nvalid = 0;
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (mptr + k) % 3;
                if (v[idx] && !wb_hold && win < 0) win = idx;
                if (v[k]) nvalid++;
            end
            exp_rdy = (win >= 0) ? (3'b001 << win) : 3'b000;
            if (req_ready !== exp_rdy) rand_err++;
            if (nvalid >= 2 && !wb_hold && mbusy < 255) mbusy++;
            for (int i = 0; i < 3; i++) begin
                pv[i] = v[i]; pa[i] = a[i]; pd[i] = d[i];
                if (v[i] && !wb_hold) begin
                    wait_c[i]++;
                    if (i == win) begin
                        if (wait_c[i] > max_wait) max_wait = wait_c[i];
                        wait_c[i] = 0;
                    end
                end
            end
            pwin = win;
            if (win >= 0) begin
`ifdef WB_ARB_X0_DROP_EN
                exp_wen = (a[win] != 5'd0);
`else
                exp_wen = 1'b1;
`endif
                last_a = a[win];
                last_d = d[win];
                last_g = 2'(win);
                acc_cnt++;
                if (exp_wen) exp_emit++;
                mptr = (win + 1) % 3;
                v[win] = 1'b0;
            end else begin
                exp_wen = 1'b0;
            end
            step();
            if (rf_wen !== exp_wen || rf_waddr !== last_a || rf_wdata !== last_d ||
                grant_id !== last_g) begin
                rand_err++;
            end
            if (rf_wen === 1'b1) emit_cnt++;
        end
        clear_src();
        wb_hold = 1'b0;
        $display("random phase: %0d accepts, %0d emitted writes, max wait %0d", acc_cnt, emit_cnt, max_wait);
        check_val("t6_port_errors", 64'(rand_err), 0);
        check_val("t6_stable_hold", 64'(stab_err), 0);
        check_val("t6_emit_count", 64'(emit_cnt), 64'(exp_emit));
        check_val("t6_starve_le3", 64'(max_wait <= 3), 1);
        check_val("t6_busy_sat", busy_cnt, 64'(mbusy));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
